// File: rtl/video_stream_pkg.sv
// Shared definitions for the 24/32-bit video stream packer/unpacker pair:
// word/pixel widths, byte-lane order within a pixel, the group phase type
// and the pixel record carried by the output register.
package video_stream_pkg;

  localparam int WORD_W = 32;
  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;

  // Byte lane order of one pixel inside the packed byte stream (G, B, R).
  localparam int LANE_G = 0;
  localparam int LANE_B = 1;
  localparam int LANE_R = 2;

  // Position inside a 3-word / 4-pixel group.
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  // One output pixel with its framing markers.
  typedef struct packed {
    logic            sof;
    logic            eol;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pix_t;

  localparam int PIX_REG_W = $bits(pix_t);

  // Pick channel byte 'lane' out of three bytes laid out in stream order.
  function automatic logic [CH_W-1:0] lane_byte(input logic [PIX_W-1:0] bytes3,
                                                 input int unsigned     lane);
    return bytes3[lane*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/axis_pix_reg.sv
// Output holding register for pixel-domain blocks.
// Handshake: a pixel transfers on a clock edge where out_valid & out_ready.
// The register advances (loads new data or empties) whenever it is empty or
// its current content is being taken; while out_valid & ~out_ready the
// content is frozen and 'advance' is low so upstream must not offer data.
module axis_pix_reg #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         advance,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Room for a new pixel when empty or when the held one leaves this cycle.
  always_comb begin
    advance = ~valid_q | out_ready;
  end

  // Next register content: load on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/axis_rgb_unpacker.sv
// Unpacks a 32-bit AXI4-Stream byte stream (3 words per 4 pixels, bytes in
// G,B,R order, LSB first) into one 24-bit RGB pixel per output transfer.
// Optional framing checker: define AXIS_RGB_UNPACKER_PROTO_CHECK_EN to enable
// the sticky proto_err flag, tkeep checking and misplaced-tlast handling.
// Input handshake: a word is taken on a clock edge where tvalid & tready.
// Output handshake: a pixel is taken on a clock edge where valid & ready.
module axis_rgb_unpacker
  import video_stream_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_W-1:0] in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              valid,
  input  logic              ready,
  output logic              sof,
  output logic              eol,
  output logic              proto_err,
  output phase_e            dbg_phase
);

  phase_e             phase_q, phase_d;
  logic [PIX_W-1:0]   res_q, res_d;
  logic               tlast_q, tlast_d;
  logic               proto_err_q, proto_err_d;

  logic               advance;
  logic               accept;
  logic               emit;
  phase_e             word_phase;
  logic [PIX_W-1:0]   lane_v;
  pix_t               pix_d;
  pix_t               pix_q;
  logic               misplaced_tlast;

  // A P3 pixel needs no input word, so the input stalls in P3.
  assign in_stream_tready = aresetn & advance & (phase_q != P3);
  assign accept           = in_stream_tvalid & in_stream_tready;

  // tuser always restarts a group: the word decodes as P0 whatever the phase.
  always_comb begin
    word_phase = in_stream_tuser ? P0 : phase_q;
  end

  // tlast is only meaningful on the third word of a group.
  always_comb begin
    misplaced_tlast = accept & in_stream_tlast &
                      ((word_phase == P0) | (word_phase == P1));
  end

  // Group sequencing and pixel assembly from residue bytes plus the new word.
  always_comb begin
    phase_d = phase_q;
    res_d   = res_q;
    tlast_d = tlast_q;
    emit    = 1'b0;
    lane_v  = '0;
    pix_d   = '0;
    if (advance && (phase_q == P3)) begin
      emit      = 1'b1;
      lane_v    = res_q;
      pix_d.eol = tlast_q;
      phase_d   = P0;
      res_d     = '0;
      tlast_d   = 1'b0;
    end else if (accept) begin
      emit = 1'b1;
      case (word_phase)
        P0: begin
          lane_v    = in_stream_tdata[23:0];
          res_d     = {16'h0000, in_stream_tdata[31:24]};
          pix_d.sof = in_stream_tuser;
          phase_d   = P1;
        end
        P1: begin
          lane_v  = {in_stream_tdata[15:0], res_q[7:0]};
          res_d   = {8'h00, in_stream_tdata[31:16]};
          phase_d = P2;
        end
        P2: begin
          lane_v  = {in_stream_tdata[7:0], res_q[15:0]};
          res_d   = in_stream_tdata[31:8];
          tlast_d = in_stream_tlast;
          phase_d = P3;
        end
        default: begin
          phase_d = P0;
        end
      endcase
`ifdef AXIS_RGB_UNPACKER_PROTO_CHECK_EN
      // Early end of line: close the line on this pixel and restart the group.
      if (misplaced_tlast) begin
        pix_d.eol = 1'b1;
        phase_d   = P0;
        res_d     = '0;
        tlast_d   = 1'b0;
      end
`endif
    end
    pix_d.g = lane_byte(lane_v, LANE_G);
    pix_d.b = lane_byte(lane_v, LANE_B);
    pix_d.r = lane_byte(lane_v, LANE_R);
  end

`ifdef AXIS_RGB_UNPACKER_PROTO_CHECK_EN
  logic resync;
  logic bad_keep;

  // Sticky framing error: early tlast, mid-group tuser, or partial tkeep.
  always_comb begin
    resync      = accept & in_stream_tuser & ((phase_q == P1) | (phase_q == P2));
    bad_keep    = accept & (in_stream_tkeep != 4'hF);
    proto_err_d = proto_err_q | resync | misplaced_tlast | bad_keep;
  end
`else
  logic unused_inputs;

  // Without the checker, tkeep and early tlast carry no meaning.
  always_comb begin
    unused_inputs = ^in_stream_tkeep | misplaced_tlast;
    proto_err_d   = 1'b0;
  end
`endif

  // Group state and error flag, synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q     <= P0;
      res_q       <= '0;
      tlast_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      res_q       <= res_d;
      tlast_q     <= tlast_d;
      proto_err_q <= proto_err_d;
    end
  end

  axis_pix_reg #(
    .W (PIX_REG_W)
  ) u_pix_reg (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (emit),
    .in_data   (pix_d),
    .advance   (advance),
    .out_valid (valid),
    .out_data  (pix_q),
    .out_ready (ready)
  );

  assign r         = pix_q.r;
  assign g         = pix_q.g;
  assign b         = pix_q.b;
  assign sof       = pix_q.sof;
  assign eol       = pix_q.eol;
  assign proto_err = proto_err_q;
  assign dbg_phase = phase_q;

endmodule

// File: doc/axis_rgb_unpacker.md
# axis_rgb_unpacker

Converts a 32-bit AXI4-Stream video word stream back into one 24-bit RGB pixel per transfer. Every 3 words carry 4 pixels. Sits on the read side of the frame path, after VDMA/memory readback and before pixel-domain consumers, and exactly inverts the 24→32 pixel packer. The byte stream per pixel is G, B, R, LSB-first.

## Interface
Parameters:
- None. Widths are fixed at 32-bit words and 8-bit channels.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- in_stream_tdata  in  32  packed byte stream
- in_stream_tkeep  in  4  expected 4'hF; checked only under the macro
- in_stream_tlast  in  1  end of line; legal only on the 3rd word of a group
- in_stream_tuser  in  1  start of frame; legal only on the 1st word of a group
- in_stream_tvalid  in  1  word valid
- in_stream_tready  out  1  word accepted when tvalid & tready
- r, g, b  out  8 each  pixel channels
- valid  out  1  pixel valid
- ready  in  1  downstream accepts the pixel
- sof  out  1  pixel is the first of the frame
- eol  out  1  pixel is the last of the line
- proto_err  out  1  sticky framing error (0 when the macro is absent)

## Operation
- Phase counter, values P0..P3. Residue register holds up to 3 bytes.
- P0 accepts w: pixel = {r,g,b} ← {w[23:16], w[7:0]... } with g=w[7:0], b=w[15:8], r=w[23:16]. Residue ← w[31:24]. sof ← tuser. Next phase P1.
- P1 accepts w: g=res0, b=w[7:0], r=w[15:8]. Residue ← w[31:16]. Next phase P2.
- P2 accepts w: g=res0, b=res1, r=w[7:0]. Residue ← w[31:8]. Stored tlast ← tlast. Next phase P3.
- P3 consumes no input: g=res0, b=res1, r=res2. eol ← stored tlast. Next phase P0.
- advance = ~valid | ready.
- in_stream_tready = aresetn & advance & (phase != P3).
- On advance:
  - In P3, emit the P3 pixel.
  - Otherwise, if a word is accepted, emit its pixel.
  - Otherwise, valid ← 0.
- sof is 1 only on the P0-derived pixel carrying tuser. eol is 1 only on the P3 pixel (normal operation).
- Resync on tuser in P1/P2: treat the word as P0 and discard the residue. Under the macro, also set proto_err.
- tuser with phase P3 pending: the P3 pixel is emitted first, and the tuser word is then taken in P0. No pixel is dropped.

## Timing
- Reset values:
  - valid=0, sof=0, eol=0
  - r=g=b=0
  - phase=P0, residue=0, stored tlast=0
  - proto_err=0
  - in_stream_tready=0 while aresetn=0
- Latency: registered output, 1 cycle from word acceptance to pixel valid.
- Throughput: 4 pixels per 4 cycles with continuous tvalid and ready. Input duty cycle is 3/4.
- Backpressure: while valid & ~ready, r/g/b/sof/eol hold stable and in_stream_tready=0.
- Reset asserted mid-group: residue and phase are discarded. The next accepted word is P0.

## Configuration
- Macro: AXIS_RGB_UNPACKER_PROTO_CHECK_EN.
- Defined:
  - proto_err sets sticky on any of: tlast on a P0/P1 word, tuser on a P1/P2 word, or tkeep != 4'hF on any accepted word.
  - proto_err clears only on reset.
  - Misplaced tlast: the emitted pixel gets eol=1, phase → P0, residue is dropped.
- Undefined:
  - proto_err tied 0 and tkeep ignored.
  - tlast on P0/P1 is ignored.
  - tuser resync still applies.

## Structure
- Shared package `video_stream_pkg` holds:
  - phase typedef (P0..P3)
  - byte-lane order localparams (G=0, B=1, R=2)
  - the 24/32 width constants shared with the packer
- Sub-module `axis_pix_reg`: the output holding register with the valid/ready advance logic, reusable by other pixel-domain blocks.

## Test plan
- Basic group: w0=0x04030201 (tuser=1), w1=0x08070605, w2=0x0C0B0A09 (tlast=1), ready=1.
  - Expect pixels (g,b,r) = (01,02,03) sof=1, (04,05,06), (07,08,09), (0A,0B,0C) eol=1.
  - tready pattern 1,1,1,0.
- Backpressure: same words with ready low for 3 cycles after the 1st pixel.
  - Pixel (01,02,03) is held stable.
  - tready=0 throughout the stall.
  - No pixel is lost or duplicated.
- Resync: tuser on w1 of a group.
  - That word decodes as P0 (bytes 0–2).
  - The old residue is discarded.
  - proto_err=1 with the macro, 0 without.
- Misplaced tlast on w1 (macro on): pixel eol=1, proto_err=1, next word decodes as P0.
- Reset mid-group: aresetn low for 1 cycle after w1.
  - All outputs at reset values.
  - Next word w=0x00C0B0A0 yields (A0,B0,C0).
- Long run: 1920-pixel line (1440 words), random tvalid/ready.
  - Output equals the reference pixel sequence.
  - Exactly one eol, on pixel 1920.
